// File: rtl/s2p_deframer.sv
// Serial-to-parallel deframer: rebuilds MSB-first words marked by sof and queues them in a valid/ready FIFO.
// Optional S2P_WORD_CNT_EN adds a 16-bit count of words accepted into the FIFO.
module s2p_deframer #(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              sof,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frm_err,
  output logic              ovf_err,
  input  logic              err_clr
`ifdef S2P_WORD_CNT_EN
  ,
  output logic [15:0]       word_cnt
`endif
);

  localparam int unsigned CW = $clog2(DATA_W) + 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     cnt, cnt_next;
  logic [DATA_W-1:0] sh, sh_next;
  logic              word_done, frm_evt;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] last_out;
  logic              empty, full, pop, push, ovf_evt;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    sh_next    = sh;
    word_done  = 1'b0;
    frm_evt    = 1'b0;
    case (state)
      IDLE: begin
        if (sof) begin
          sh_next             = '0;
          sh_next[DATA_W-1]   = din;
          cnt_next            = CW'(1);
          state_next          = SHIFT;
        end
      end
      SHIFT: begin
        if (sof) begin
          // premature marker: drop the partial word and restart from this bit
          frm_evt           = 1'b1;
          sh_next           = '0;
          sh_next[DATA_W-1] = din;
          cnt_next          = CW'(1);
        end else begin
          for (int unsigned i = 0; i < DATA_W; i++) begin
            if (CW'(i) == LAST - cnt) sh_next[i] = din;
          end
          cnt_next = cnt + CW'(1);
          if (cnt == LAST) begin
            word_done  = 1'b1;
            cnt_next   = '0;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      sh    <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      sh    <= sh_next;
    end
  end

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[PW-1] != rd_ptr[PW-1]);
  assign pop       = !empty && out_ready;
  assign push      = word_done && (!full || pop);
  assign ovf_evt   = word_done && full && !pop;
  assign out_valid = !empty;
  // last_out keeps the most recently popped word visible while the FIFO is empty
  assign out_data  = empty ? last_out : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_out <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= sh_next;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (pop) begin
        last_out <= mem[rd_ptr[AW-1:0]];
        rd_ptr   <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      frm_err <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      frm_err <= frm_evt || (frm_err && !err_clr);
      ovf_err <= ovf_evt || (ovf_err && !err_clr);
    end
  end

`ifdef S2P_WORD_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) word_cnt <= '0;
    else if (push) word_cnt <= word_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_s2p_deframer.sv
// Directed self-checking bench for s2p_deframer with DATA_W=4, FIFO_DEPTH=2.
module tb_s2p_deframer;

  logic       clk;
  logic       rst;
  logic       din;
  logic       sof;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       frm_err;
  logic       ovf_err;
  logic       err_clr;
`ifdef S2P_WORD_CNT_EN
  logic [15:0] word_cnt;
`endif

  int checks = 0;
  int fails  = 0;

  s2p_deframer #(.DATA_W(4), .FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .sof       (sof),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frm_err   (frm_err),
    .ovf_err   (ovf_err),
    .err_clr   (err_clr)
`ifdef S2P_WORD_CNT_EN
    ,
    .word_cnt  (word_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs; returns 1 time unit after the sampling edge.
  task automatic tick(input logic s, input logic d);
    sof = s;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [3:0] w);
    tick(1'b1, w[3]);
    tick(1'b0, w[2]);
    tick(1'b0, w[1]);
    tick(1'b0, w[0]);
  endtask

  task automatic test_reset();
    rst = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, i[0]);
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid[%0d]: got %b expected 0", i, out_valid); end
      checks++; if (out_data !== 4'h0) begin fails++; $display("FAIL reset_data[%0d]: got %h expected 0", i, out_data); end
      checks++; if (frm_err !== 1'b0 || ovf_err !== 1'b0) begin fails++; $display("FAIL reset_err[%0d]: got frm=%b ovf=%b expected 0 0", i, frm_err, ovf_err); end
`ifdef S2P_WORD_CNT_EN
      checks++; if (word_cnt !== 16'd0) begin fails++; $display("FAIL reset_wcnt[%0d]: got %0d expected 0", i, word_cnt); end
`endif
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_no_word: got valid=%b expected 0", out_valid); end
  endtask

  task automatic test_single_word();
    out_ready = 1'b1;
    send_word(4'hB);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== 4'hB) begin fails++; $display("FAIL single_data: got %h expected b", out_data); end
    tick(1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_popped: got %b expected 0", out_valid); end
    checks++; if (out_data !== 4'hB) begin fails++; $display("FAIL single_hold: got %h expected b", out_data); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send_word(4'hA);
    checks++; if (out_valid !== 1'b1 || out_data !== 4'hA) begin fails++; $display("FAIL b2b_first: got valid=%b data=%h expected 1 a", out_valid, out_data); end
    tick(1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_gap: got valid=%b expected 0", out_valid); end
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== 4'h5) begin fails++; $display("FAIL b2b_second: got valid=%b data=%h expected 1 5", out_valid, out_data); end
    checks++; if (frm_err !== 1'b0) begin fails++; $display("FAIL b2b_frm: got %b expected 0", frm_err); end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_framing_error();
    out_ready = 1'b1;
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    send_word(4'h6);
    checks++; if (frm_err !== 1'b1) begin fails++; $display("FAIL frm_set: got %b expected 1", frm_err); end
    checks++; if (out_valid !== 1'b1 || out_data !== 4'h6) begin fails++; $display("FAIL frm_word: got valid=%b data=%h expected 1 6", out_valid, out_data); end
    tick(1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0 || frm_err !== 1'b1) begin fails++; $display("FAIL frm_only_one: got valid=%b frm=%b expected 0 1", out_valid, frm_err); end
    err_clr = 1'b1;
    tick(1'b0, 1'b0);
    err_clr = 1'b0;
    checks++; if (frm_err !== 1'b0) begin fails++; $display("FAIL frm_clear: got %b expected 0", frm_err); end
    // error event coinciding with err_clr keeps the flag set
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    err_clr = 1'b1;
    tick(1'b1, 1'b1);
    err_clr = 1'b0;
    checks++; if (frm_err !== 1'b1) begin fails++; $display("FAIL frm_clr_collide: got %b expected 1", frm_err); end
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== 4'h9) begin fails++; $display("FAIL frm_restart_word: got valid=%b data=%h expected 1 9", out_valid, out_data); end
    err_clr = 1'b1;
    tick(1'b0, 1'b0);
    err_clr = 1'b0;
    checks++; if (frm_err !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL frm_final: got frm=%b valid=%b expected 0 0", frm_err, out_valid); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    send_word(4'h1);
    checks++; if (out_valid !== 1'b1 || out_data !== 4'h1) begin fails++; $display("FAIL ovf_first: got valid=%b data=%h expected 1 1", out_valid, out_data); end
    send_word(4'h2);
    checks++; if (ovf_err !== 1'b0 || out_data !== 4'h1) begin fails++; $display("FAIL ovf_full: got ovf=%b data=%h expected 0 1", ovf_err, out_data); end
    send_word(4'h3);
    checks++; if (ovf_err !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b expected 1", ovf_err); end
    checks++; if (out_data !== 4'h1) begin fails++; $display("FAIL ovf_head: got %h expected 1", out_data); end
    out_ready = 1'b1;
    tick(1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== 4'h2) begin fails++; $display("FAIL ovf_drain2: got valid=%b data=%h expected 1 2", out_valid, out_data); end
    tick(1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0 || out_data !== 4'h2) begin fails++; $display("FAIL ovf_drained: got valid=%b data=%h expected 0 2", out_valid, out_data); end
    checks++; if (ovf_err !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b expected 1", ovf_err); end
    err_clr = 1'b1;
    tick(1'b0, 1'b0);
    err_clr = 1'b0;
    checks++; if (ovf_err !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b expected 0", ovf_err); end
  endtask

  task automatic test_full_with_pop();
    out_ready = 1'b0;
    send_word(4'h1);
    send_word(4'h2);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    out_ready = 1'b1;
    tick(1'b0, 1'b1);
    checks++; if (ovf_err !== 1'b0) begin fails++; $display("FAIL fp_no_ovf: got %b expected 0", ovf_err); end
    checks++; if (out_valid !== 1'b1 || out_data !== 4'h2) begin fails++; $display("FAIL fp_second: got valid=%b data=%h expected 1 2", out_valid, out_data); end
    tick(1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== 4'h3) begin fails++; $display("FAIL fp_third: got valid=%b data=%h expected 1 3", out_valid, out_data); end
    tick(1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0 || ovf_err !== 1'b0) begin fails++; $display("FAIL fp_empty: got valid=%b ovf=%b expected 0 0", out_valid, ovf_err); end
`ifdef S2P_WORD_CNT_EN
    // B, A, 5, 6, 9, 1, 2 (3 dropped), then 1, 2, 3
    checks++; if (word_cnt !== 16'd10) begin fails++; $display("FAIL fp_wcnt: got %0d expected 10", word_cnt); end
`endif
  endtask

  initial begin
    sof = 1'b0; din = 1'b0; rst = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_framing_error();
    test_overflow();
    test_full_with_pop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
